// File: rtl/sqrt2_arbiter.sv
// Round-robin arbiter sharing one sqrt2 half-precision square-root unit.
// Sequences operand launch, result wait with timeout, and response handshake.
module sqrt2_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [16*N_REQ-1:0]  REQ_DATA,
    output logic [N_REQ-1:0]     REQ_READY,
    output logic [N_REQ-1:0]     RSP_VALID,
    input  logic [N_REQ-1:0]     RSP_READY,
    output logic [15:0]          RSP_DATA,
    output logic [3:0]           RSP_FLAGS,
    inout  wire  [15:0]          SQ_IO_DATA,
    output logic                 SQ_ENABLE,
    input  logic                 SQ_RESULT,
    input  logic                 SQ_IS_NAN,
    input  logic                 SQ_IS_PINF,
    input  logic                 SQ_IS_NINF
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   grant;
    logic [IW-1:0]   sel;
    logic            sel_ok;
    logic [15:0]     operand;
    logic [CW-1:0]   cnt;
    logic            drive;
    logic            expired;

    // Search upward from the pointer, wrapping, for the first valid requester.
    always_comb begin
        sel    = '0;
        sel_ok = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!sel_ok && REQ_VALID[(int'(ptr) + k) % N_REQ]) begin
                sel    = IW'((int'(ptr) + k) % N_REQ);
                sel_ok = 1'b1;
            end
        end
    end

    assign expired    = (cnt == CW'(TIMEOUT - 1));
    assign SQ_IO_DATA = drive ? operand : 16'hzzzz;

    always_comb begin
        state_nx  = state;
        REQ_READY = '0;
        RSP_VALID = '0;
        SQ_ENABLE = 1'b0;
        drive     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sel_ok && RST_N) begin
                    REQ_READY[sel] = 1'b1;
                    state_nx       = LAUNCH;
                end
            end
            LAUNCH: begin
                SQ_ENABLE = 1'b1;
                drive     = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                SQ_ENABLE = 1'b1;
                if (SQ_RESULT || expired) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                RSP_VALID[grant] = 1'b1;
                if (RSP_READY[grant]) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            operand   <= '0;
            cnt       <= '0;
            RSP_DATA  <= '0;
            RSP_FLAGS <= '0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (sel_ok) begin
                        grant   <= sel;
                        operand <= REQ_DATA[16*int'(sel) +: 16];
                        ptr     <= (sel == IW'(N_REQ - 1)) ? '0 : sel + IW'(1);
                    end
                end
                LAUNCH: cnt <= '0;
                WAIT: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (SQ_RESULT) begin
                        RSP_DATA  <= SQ_IO_DATA;
                        RSP_FLAGS <= {1'b0, SQ_IS_NINF, SQ_IS_PINF, SQ_IS_NAN};
                    end else if (expired) begin
                        RSP_DATA  <= 16'h7E00;
                        RSP_FLAGS <= 4'b1000;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sqrt2_arbiter.sv
// Directed bench for sqrt2_arbiter with a behavioural sqrt2 stub on the bus.
// The stub answers a fixed operand table after a programmable latency.
module tb_sqrt2_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [63:0] req_data;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [15:0] rsp_data;
    logic [3:0]  rsp_flags;
    tri1  [15:0] sq_bus;
    logic        sq_enable;
    logic        sq_result;
    logic        sq_nan;
    logic        sq_pinf;
    logic        sq_ninf;

    int checks = 0;
    int errors = 0;

    int          stub_cnt   = 0;
    int          stub_lat   = 1;
    bit          stub_never = 1'b0;
    logic        stub_res   = 1'b0;
    logic [15:0] stub_op    = 16'h0000;
    logic [15:0] st_val;
    logic        st_nan;
    logic        st_pinf;

    always #5 clk = ~clk;

    sqrt2_arbiter #(.N_REQ(4), .TIMEOUT(8)) dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .REQ_VALID  (req_valid),
        .REQ_DATA   (req_data),
        .REQ_READY  (req_ready),
        .RSP_VALID  (rsp_valid),
        .RSP_READY  (rsp_ready),
        .RSP_DATA   (rsp_data),
        .RSP_FLAGS  (rsp_flags),
        .SQ_IO_DATA (sq_bus),
        .SQ_ENABLE  (sq_enable),
        .SQ_RESULT  (sq_result),
        .SQ_IS_NAN  (sq_nan),
        .SQ_IS_PINF (sq_pinf),
        .SQ_IS_NINF (sq_ninf)
    );

    always_comb begin
        st_val  = 16'h0000;
        st_nan  = 1'b0;
        st_pinf = 1'b0;
        case (stub_op)
            16'h4400: st_val = 16'h4000;
            16'h3C00: st_val = 16'h3C00;
            16'h7C00: begin st_val = 16'h7C00; st_pinf = 1'b1; end
            16'hBC00: begin st_val = 16'h7E00; st_nan = 1'b1; end
            16'h0001: st_val = 16'h0C00;
            16'h8000: st_val = 16'h8000;
            default:  st_val = 16'h0000;
        endcase
    end

    assign sq_result = stub_res;
    assign sq_nan    = stub_res & st_nan;
    assign sq_pinf   = stub_res & st_pinf;
    assign sq_ninf   = 1'b0;
    assign sq_bus    = (stub_res && sq_enable) ? st_val : 16'hzzzz;

    // The stub resets whenever ENABLE is low, like the real unit.
    always @(posedge clk) begin
        if (!sq_enable) begin
            stub_cnt <= 0;
            stub_res <= 1'b0;
        end else begin
            if (stub_cnt == 0) stub_op <= sq_bus;
            stub_cnt <= stub_cnt + 1;
            if (!stub_never && stub_cnt == stub_lat) stub_res <= 1'b1;
        end
    end

    task automatic serve(input bit drop, input int stall,
                         output int g, output int lat,
                         output logic [15:0] d, output logic [3:0] f,
                         output logic [3:0] vld, output logic [15:0] d_end,
                         output logic [3:0] rdy_seen);
        int n;
        g = -1; lat = 0; d = '0; f = '0; vld = '0;
        d_end = '0; rdy_seen = '0; n = 0;
        while (req_ready == '0 && n < 50) begin
            @(negedge clk); #1; n++;
        end
        for (int i = 0; i < 4; i++) if (req_ready[i]) g = i;
        @(negedge clk);
        if (drop && g >= 0) req_valid[g] = 1'b0;
        #1; lat = 1;
        while (rsp_valid == '0 && lat < 50) begin
            @(negedge clk); #1; lat++;
        end
        vld = rsp_valid; d = rsp_data; f = rsp_flags; d_end = rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk); #1;
            rdy_seen |= req_ready;
            d_end = rsp_data;
        end
        rsp_ready = rsp_valid;
        @(negedge clk);
        rsp_ready = '0;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 4'b1111; req_data = 64'h1234_5678_9ABC_DEF0;
        rsp_ready = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 4'b0000) begin errors++;
            $display("FAIL reset_rsp_valid got %b want 0000", rsp_valid); end
        checks++; if (rsp_data !== 16'h0000 || rsp_flags !== 4'h0) begin errors++;
            $display("FAIL reset_rsp got %h/%b want 0000/0000", rsp_data, rsp_flags); end
        checks++; if (sq_enable !== 1'b0 || sq_bus !== 16'hFFFF) begin errors++;
            $display("FAIL reset_bus got en=%b bus=%h want 0/ffff", sq_enable, sq_bus); end
        @(negedge clk); req_valid = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_single;
        stub_never = 1'b0; stub_lat = 1;
        req_data[15:0] = 16'h4400; req_valid = 4'b0001; #1;
        checks++; if (req_ready !== 4'b0001 || sq_bus !== 16'hFFFF) begin errors++;
            $display("FAIL single_accept got rdy=%b bus=%h want 0001/ffff", req_ready, sq_bus); end
        @(negedge clk); req_valid = '0; #1;
        checks++; if (sq_enable !== 1'b1 || sq_bus !== 16'h4400) begin errors++;
            $display("FAIL single_launch got en=%b bus=%h want 1/4400", sq_enable, sq_bus); end
        @(negedge clk); #1;
        checks++; if (sq_enable !== 1'b1 || sq_bus !== 16'hFFFF) begin errors++;
            $display("FAIL single_wait got en=%b bus=%h want 1/ffff", sq_enable, sq_bus); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 4'b0000 || sq_bus !== 16'h4000) begin errors++;
            $display("FAIL single_result got vld=%b bus=%h want 0000/4000", rsp_valid, sq_bus); end
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 4'b0001 || rsp_data !== 16'h4000 || rsp_flags !== 4'h0) begin
            errors++;
            $display("FAIL single_rsp got %b %h %b want 0001 4000 0000", rsp_valid, rsp_data, rsp_flags); end
        checks++; if (sq_enable !== 1'b0 || sq_bus !== 16'hFFFF) begin errors++;
            $display("FAIL single_resp_bus got en=%b bus=%h want 0/ffff", sq_enable, sq_bus); end
        rsp_ready = 4'b1110;
        @(negedge clk); #1;
        checks++; if (rsp_valid !== 4'b0001) begin errors++;
            $display("FAIL single_foreign_ready got %b want 0001", rsp_valid); end
        rsp_ready = 4'b0001;
        @(negedge clk); rsp_ready = '0; #1;
        checks++; if (rsp_valid !== 4'b0000) begin errors++;
            $display("FAIL single_done got %b want 0000", rsp_valid); end
    endtask

    task automatic test_multi;
        int g, lat;
        logic [15:0] d, de;
        logic [3:0] f, v, rs;
        int          exp_g [3] = '{1, 2, 3};
        logic [15:0] exp_d [3] = '{16'h3C00, 16'h7C00, 16'h7E00};
        logic [3:0]  exp_f [3] = '{4'b0000, 4'b0010, 4'b0001};
        stub_lat = 0;
        req_data = {16'hBC00, 16'h7C00, 16'h3C00, 16'h0000};
        req_valid = 4'b1110; #1;
        for (int i = 0; i < 3; i++) begin
            serve(1'b1, 0, g, lat, d, f, v, de, rs);
            checks++; if (g !== exp_g[i] || d !== exp_d[i] || f !== exp_f[i]) begin errors++;
                $display("FAIL multi_%0d got g=%0d %h %b want g=%0d %h %b",
                         i, g, d, f, exp_g[i], exp_d[i], exp_f[i]); end
            checks++; if (lat !== 3) begin errors++;
                $display("FAIL multi_lat_%0d got %0d want 3", i, lat); end
        end
    endtask

    task automatic test_fairness;
        int g, lat;
        logic [15:0] d, de;
        logic [3:0] f, v, rs;
        logic [15:0] exp_d [4] = '{16'h4000, 16'h3C00, 16'h7C00, 16'h0C00};
        stub_lat = 2;
        req_data = {16'h0001, 16'h7C00, 16'h3C00, 16'h4400};
        req_valid = 4'b1111; #1;
        for (int i = 0; i < 8; i++) begin
            serve(1'b0, (i == 5) ? 3 : 0, g, lat, d, f, v, de, rs);
            checks++; if (g !== i % 4 || d !== exp_d[i % 4] || lat !== 5) begin errors++;
                $display("FAIL fair_%0d got g=%0d %h lat=%0d want g=%0d %h lat=5",
                         i, g, d, lat, i % 4, exp_d[i % 4]); end
            if (i == 5) begin
                checks++; if (de !== 16'h3C00 || rs !== 4'b0000 || v !== 4'b0010) begin errors++;
                    $display("FAIL fair_stall got %h rdy=%b vld=%b want 3c00 0000 0010", de, rs, v); end
            end
        end
        req_valid = '0;
        @(negedge clk); #1;
    endtask

    task automatic test_timeout;
        int g, lat;
        logic [15:0] d, de;
        logic [3:0] f, v, rs;
        stub_never = 1'b1;
        req_data[15:0] = 16'h4400; req_valid = 4'b0001; #1;
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 0 || lat !== 10 || d !== 16'h7E00 || f !== 4'b1000) begin errors++;
            $display("FAIL timeout got g=%0d lat=%0d %h %b want 0 10 7e00 1000", g, lat, d, f); end
        stub_never = 1'b0; stub_lat = 1;
        req_data[31:16] = 16'h3C00; req_valid = 4'b0010; #1;
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 1 || lat !== 4 || d !== 16'h3C00 || f !== 4'b0000) begin errors++;
            $display("FAIL after_timeout got g=%0d lat=%0d %h %b want 1 4 3c00 0000", g, lat, d, f); end
    endtask

    task automatic test_back_to_back;
        int g, lat;
        logic [15:0] d, de;
        logic [3:0] f, v, rs;
        stub_lat = 3;
        req_data[47:32] = 16'h0001; req_valid = 4'b0100; #1;
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 2 || lat !== 6 || d !== 16'h0C00 || f !== 4'b0000) begin errors++;
            $display("FAIL b2b_denorm got g=%0d lat=%0d %h %b want 2 6 0c00 0000", g, lat, d, f); end
        checks++; if (sq_enable !== 1'b0) begin errors++;
            $display("FAIL b2b_gap got en=%b want 0", sq_enable); end
        req_data[47:32] = 16'h8000; req_valid = 4'b0100; #1;
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 2 || d !== 16'h8000 || f !== 4'b0000) begin errors++;
            $display("FAIL b2b_zero got g=%0d %h %b want 2 8000 0000", g, d, f); end
    endtask

    task automatic test_reset_mid;
        int g, lat;
        logic [15:0] d, de;
        logic [3:0] f, v, rs;
        logic [3:0] seen;
        stub_never = 1'b1;
        req_data[15:0] = 16'h4400; req_valid = 4'b0001; #1;
        @(negedge clk); req_valid = '0;
        @(negedge clk); #1;
        checks++; if (sq_enable !== 1'b1) begin errors++;
            $display("FAIL mid_wait got en=%b want 1", sq_enable); end
        rst_n = 1'b0; #1;
        checks++; if (sq_enable !== 1'b0 || sq_bus !== 16'hFFFF || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got en=%b bus=%h vld=%b want 0 ffff 0000", sq_enable, sq_bus, rsp_valid); end
        @(negedge clk); rst_n = 1'b1;
        seen = '0;
        for (int i = 0; i < 12; i++) begin @(negedge clk); #1; seen |= rsp_valid; end
        checks++; if (seen !== 4'b0000) begin errors++;
            $display("FAIL mid_no_rsp got %b want 0000", seen); end
        stub_never = 1'b0; stub_lat = 0;
        req_data = {16'hBC00, 16'h0000, 16'h0000, 16'h4400};
        req_valid = 4'b1001; #1;
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 0 || d !== 16'h4000) begin errors++;
            $display("FAIL mid_ptr got g=%0d %h want 0 4000", g, d); end
        serve(1'b1, 0, g, lat, d, f, v, de, rs);
        checks++; if (g !== 3 || d !== 16'h7E00 || f !== 4'b0001) begin errors++;
            $display("FAIL mid_next got g=%0d %h %b want 3 7e00 0001", g, d, f); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_fairness();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
